// File: rtl/rounding_shift_pipe.sv
// Requantiser: rounding right-shift by 2^shift (4 modes), then clamp to OUT_W.
// Latency 2 cycles; full-pipeline stall, in_ready = !s1_vld | !s2_vld | out_ready.
module rounding_shift_pipe #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6,
    parameter int SIGNED  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat
);

    localparam int SW = $clog2(IN_W);
    localparam logic [IN_W:0] ONE = (IN_W+1)'(1);
    localparam logic signed [IN_W:0] MAX_V =
        $signed((ONE << ((SIGNED != 0) ? OUT_W - 1 : OUT_W)) - ONE);
    localparam logic signed [IN_W:0] MIN_V =
        (SIGNED != 0) ? $signed(-(ONE << (OUT_W - 1))) : '0;

    logic                    s1_vld_q, s1_vld_d;
    logic signed [IN_W:0]    s1_q_q, s1_q_d;
    logic                    s2_vld_q, s2_vld_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic                    adv1, adv2;
    logic [SW-1:0]           s;
    logic signed [IN_W:0]    xe, q0, rnd;
    logic [IN_W:0]           mask, r, half;
    logic                    gt, eq, inc;
    logic [OUT_W-1:0]        clamp_dat;
    logic                    clamp_sat;

    assign adv2      = !s2_vld_q || out_ready;
    assign adv1      = !s1_vld_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_vld_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // One extra bit of headroom keeps q0 + 1 and the most-negative input exact.
    always_comb begin
        xe = (SIGNED != 0) ? $signed({in_data[IN_W-1], in_data}) : $signed({1'b0, in_data});
        if (int'(in_shift) > IN_W - 1) s = SW'(IN_W - 1);
        else                           s = SW'(in_shift);
        q0   = xe >>> s;
        mask = (ONE << s) - ONE;
        r    = xe & mask;
        half = (ONE << s) >> 1;
        gt   = r > half;
        eq   = r == half;
        case (in_mode)
            2'd0:    inc = 1'b0;
            2'd1:    inc = xe[IN_W] ? gt : (gt || eq);
            2'd2:    inc = gt || eq;
            default: inc = gt || (eq && q0[0]);
        endcase
        if (s == '0) rnd = xe;
        else         rnd = q0 + $signed({{IN_W{1'b0}}, inc});
    end

    always_comb begin
        clamp_sat = 1'b1;
        if (s1_q_q > MAX_V)      clamp_dat = MAX_V[OUT_W-1:0];
        else if (s1_q_q < MIN_V) clamp_dat = MIN_V[OUT_W-1:0];
        else begin
            clamp_dat = s1_q_q[OUT_W-1:0];
            clamp_sat = 1'b0;
        end
    end

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_q_d     = s1_q_q;
        s2_vld_d   = s2_vld_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (adv1) begin
            s1_vld_d = in_valid;
            s1_q_d   = rnd;
        end
        if (adv2) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_data_d = clamp_dat;
                out_sat_d  = clamp_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_q_q     <= '0;
            s2_vld_q   <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_q_q     <= s1_q_d;
            s2_vld_q   <= s2_vld_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule
